// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI peripheral: FSM states, pin indices
// and the mode-0 edge selection.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } spi_state_t;

  // Mode 0: CPOL=0, CPHA=0 -> capture on sck rise, launch on sck fall.
  localparam logic SCK_SAMPLE_RISE = 1'b1;

  localparam int PIN_SDI   = 0;
  localparam int PIN_SCK   = 1;
  localparam int PIN_CS    = 2;
  localparam int PIN_COUNT = 3;

  // Idle levels of the pins as seen through the synchronizers after reset.
  localparam logic [PIN_COUNT-1:0] PIN_RESET_VALS = 3'b100;

endpackage

// File: rtl/spi_peripheral_if.sv
// Bundle of SPI pins and the parallel word/status side of the peripheral.
interface spi_peripheral_if #(
  parameter int WIDTH = 24
);
  logic             sck;
  logic             cs;
  logic             sdi;
  logic             sdo;
  logic             sdo_oe;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             frame_err;
  logic             busy;

  modport slave (
    input  sck, cs, sdi, tx_data,
    output sdo, sdo_oe, rx_data, rx_valid, frame_err, busy
  );

  modport master (
    output sck, cs, sdi, tx_data,
    input  sdo, sdo_oe, rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall pulses
// derived from the synchronized level.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic [SYNC_STAGES:0]   prime_reg;

  // Edges stay masked until the chain and prev_reg hold real pin samples, so
  // a pin that differs from RESET_VAL at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= {SYNC_STAGES{RESET_VAL}};
      prev_reg  <= RESET_VAL;
      prime_reg <= '0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], pin};
      prev_reg  <= sync_reg[SYNC_STAGES-1];
      prime_reg <= {prime_reg[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = prime_reg[SYNC_STAGES] &  level & ~prev_reg;
  assign fall  = prime_reg[SYNC_STAGES] & ~level &  prev_reg;

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI peripheral: fixed-width full-duplex frames, clocked entirely by
// clk with the SPI pins oversampled through synchronizers.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  spi_peripheral_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(WIDTH + 1);

  logic [PIN_COUNT-1:0] pin_vec;
  logic [PIN_COUNT-1:0] pin_level;
  logic [PIN_COUNT-1:0] pin_rise;
  logic [PIN_COUNT-1:0] pin_fall;

  assign pin_vec = {bus.cs, bus.sck, bus.sdi};

  generate
    for (genvar gi = 0; gi < PIN_COUNT; gi++) begin : g_sync
      spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (PIN_RESET_VALS[gi])
      ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (pin_vec[gi]),
        .level (pin_level[gi]),
        .rise  (pin_rise[gi]),
        .fall  (pin_fall[gi])
      );
    end
  endgenerate

  logic sample_edge;
  logic shift_edge;
  logic unused_pins;

  assign sample_edge = SCK_SAMPLE_RISE ? pin_rise[PIN_SCK] : pin_fall[PIN_SCK];
  assign shift_edge  = SCK_SAMPLE_RISE ? pin_fall[PIN_SCK] : pin_rise[PIN_SCK];
  assign unused_pins = ^{pin_level[PIN_CS], pin_level[PIN_SCK],
                         pin_rise[PIN_SDI], pin_fall[PIN_SDI]};

  spi_state_t       state_reg;
  logic [WIDTH-1:0] tx_reg;
  logic [WIDTH-1:0] rx_reg;
  logic [WIDTH-1:0] rx_data_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             rx_valid_reg;
  logic             frame_err_reg;
  logic             busy_reg;
  logic             oe_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      tx_reg        <= '0;
      rx_reg        <= '0;
      rx_data_reg   <= '0;
      cnt_reg       <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      busy_reg      <= 1'b0;
      oe_reg        <= 1'b0;
    end else begin
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pin_fall[PIN_CS]) begin
            state_reg <= ST_LOAD;
            busy_reg  <= 1'b1;
            oe_reg    <= 1'b1;
          end
        end
        ST_LOAD: begin
          tx_reg    <= bus.tx_data;
          rx_reg    <= '0;
          cnt_reg   <= '0;
          state_reg <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // A final sck rise coinciding with cs rise is still captured here,
          // so DONE always judges the complete count.
          if (sample_edge) begin
            if (cnt_reg < CNT_FULL) rx_reg <= {rx_reg[WIDTH-2:0], pin_level[PIN_SDI]};
            if (cnt_reg != CNT_OVER) cnt_reg <= cnt_reg + CNT_W'(1);
          end
          if (shift_edge && (cnt_reg != '0)) tx_reg <= {tx_reg[WIDTH-2:0], 1'b0};
          if (pin_rise[PIN_CS]) begin
            state_reg <= ST_DONE;
            oe_reg    <= 1'b0;
          end
        end
        ST_DONE: begin
          if (cnt_reg == CNT_FULL) begin
            rx_data_reg  <= rx_reg;
            rx_valid_reg <= 1'b1;
          end else begin
            frame_err_reg <= 1'b1;
          end
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.sdo       = tx_reg[WIDTH-1];
  assign bus.sdo_oe    = oe_reg;
  assign bus.rx_data   = rx_data_reg;
  assign bus.rx_valid  = rx_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Parameters
REQ-001 The module SHALL take parameter WIDTH, default 24, giving the bits per frame in each direction.
REQ-002 The module SHALL take parameter SYNC_STAGES, default 2, giving the synchronizer flop count per input pin (minimum 2).

Interface
REQ-003 The module SHALL have input clk, 1 bit, the system clock; it is the only clock.
REQ-004 The module SHALL have input rst, 1 bit, a synchronous active-high reset.
REQ-005 The module SHALL have input sck, 1 bit, the SPI clock from the external controller (asynchronous).
REQ-006 The module SHALL have input cs, 1 bit, the active-low chip select (asynchronous).
REQ-007 The module SHALL have input sdi, 1 bit, serial data from the controller (asynchronous).
REQ-008 The module SHALL have output sdo, 1 bit, serial data to the controller.
REQ-009 The module SHALL have output sdo_oe, 1 bit, the sdo output-enable, high while the frame is selected.
REQ-010 The module SHALL have input tx_data, WIDTH bits, the word returned in the next frame.
REQ-011 The module SHALL have output rx_data, WIDTH bits, the last complete received word.
REQ-012 The module SHALL have output rx_valid, 1 bit, a one-clk pulse when rx_data updates.
REQ-013 The module SHALL have output frame_err, 1 bit, a one-clk pulse on a short or long frame.
REQ-014 The module SHALL have output busy, 1 bit, high from frame start until frame end.

Function
REQ-015 SPI mode 0 SHALL be used: sample sdi on sck rise, change sdo on sck fall, MSB first.
REQ-016 sck, cs and sdi SHALL each pass through SYNC_STAGES flops and then an edge detector; all decisions SHALL use the synchronized versions.
REQ-017 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-018 IDLE SHALL go to LOAD on a synchronized cs falling edge.
REQ-019 LOAD SHALL last one clk, copy tx_data into the tx shift register, clear the bit counter, and go to SHIFT.
REQ-020 SHIFT SHALL shift the synchronized sdi into the rx shift register on each sck rising edge and increment the bit counter.
REQ-021 SHIFT SHALL shift the tx register left on each sck falling edge, but only after at least one rising edge.
REQ-022 SHIFT SHALL go to DONE on a synchronized cs rising edge.
REQ-023 DONE SHALL last one clk and return to IDLE.
REQ-024 In DONE, if the count equals WIDTH, rx_data SHALL take the rx register and rx_valid SHALL pulse.
REQ-025 In DONE, if the count is not WIDTH, rx_data SHALL hold and frame_err SHALL pulse.
REQ-026 The bit counter SHALL saturate at WIDTH+1; rising edges beyond WIDTH SHALL not shift rx and SHALL force frame_err at DONE.
REQ-027 sdo SHALL equal tx register MSB; after WIDTH shifts sdo SHALL be 0.
REQ-028 sdo_oe SHALL be high in LOAD and SHIFT only.
REQ-029 busy SHALL be high in LOAD, SHIFT and DONE.
REQ-030 tx_data SHALL be sampled only in LOAD; changes at other times SHALL not affect the current frame.
REQ-031 If sck rise and cs rise are detected in the same clk, the sample SHALL be taken and counted before the frame is evaluated.
REQ-032 An sck edge seen in IDLE SHALL be ignored.
REQ-033 Timing contract: clk >= 8x sck frequency, and cs-fall-to-first-sck-rise >= SYNC_STAGES+3 clk.
REQ-034 Latency from the last cs rise at the pin to the rx_valid pulse SHALL be SYNC_STAGES+2 clk.

Reset
REQ-035 On rst, the FSM SHALL go to IDLE; rx_data, the shift registers and the counter SHALL be 0; rx_valid, frame_err, busy, sdo and sdo_oe SHALL be 0.
REQ-036 The synchronizer flops SHALL reset to cs=1, sck=0 and sdi=0.
REQ-037 If rst is asserted mid-frame, the frame SHALL be discarded without frame_err; if cs is low at release, the next frame SHALL start only after cs goes high then low.

Structure
REQ-038 The state enum for IDLE/LOAD/SHIFT/DONE SHALL live in shared package spi_pkg, alongside the mode-0 edge-select constants.
REQ-039 One sub-module, spi_pin_sync, SHALL implement the synchronizer plus rise/fall pulse outputs, with a reset-value parameter, and SHALL be instantiated three times.

Verification
REQ-040 24-bit frame, sdi=0xA5C3F0, tx_data=0x123456, sck=clk/10 -> rx_data=0xA5C3F0, one rx_valid pulse, sdo bitstream 0x123456.
REQ-041 Frame with 23 sck pulses -> frame_err pulse, rx_data keeps its prior value, no rx_valid.
REQ-042 Frame with 25 sck pulses, sdi=0xFFFFFF then 0 -> frame_err pulse, rx_data unchanged.
REQ-043 tx_data changed from 0x123456 to 0xABCDEF mid-frame -> sdo still sends 0x123456; the next frame sends 0xABCDEF.
REQ-044 rst pulse at bit 10 with cs held low -> all outputs 0, no rx_valid or frame_err; a later cs high-then-low frame of 0x000001 is received correctly.
REQ-045 Back-to-back frames with 4 clk of cs high between them -> two rx_valid pulses with the correct words.
